// File: rtl/maze_pkg.sv
// Shared types and sizes for the maze map block.
// Holds the controller state encoding and the row storage type.
package maze_pkg;

   localparam int MAZE_DIM = 16;
   localparam int IDX_W    = 4;

   typedef logic [15:0] row_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_READY
   } state_t;

endpackage

// File: rtl/maze_row_counter.sv
// Row index counter shared by the LOAD and CLEAR sweeps.
// Sync clear, count enable, and a terminal-count flag on the last row.
module maze_row_counter
   import maze_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + IDX_W'(1);
      end
   end

   assign tc = (cnt == {IDX_W{1'b1}});

endmodule

// File: rtl/maze_map.sv
// Maze wall/visited map with row-serial load and sweep clear.
// Dout reports a blocked cell; everything is blocked until READY.
module maze_map
   import maze_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             load_valid,
   input  row_t             load_data,
   output logic             load_ready,
   input  logic [IDX_W-1:0] X,
   input  logic [IDX_W-1:0] Y,
   input  logic             mark,
   input  logic             clear_marks,
   output logic             Dout,
   output logic             loaded,
   output logic             busy,
   output logic             bad_maze
);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] row;
   logic             row_tc;
   logic             cnt_clr;
   logic             cnt_en;
   logic             wr_row;
   logic             clr_row;
   logic             set_mark;

   row_t wall    [MAZE_DIM];
   row_t visited [MAZE_DIM];

   maze_row_counter u_row (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (row),
      .tc  (row_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // load_start outranks every other request in every state
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      wr_row    = 1'b0;
      clr_row   = 1'b0;
      set_mark  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (load_start) begin
               state_nxt = S_LOAD;
               cnt_clr   = 1'b1;
            end
         end
         S_LOAD: begin
            if (load_start) begin
               cnt_clr = 1'b1;
            end else if (load_valid) begin
               wr_row = 1'b1;
               cnt_en = 1'b1;
               if (row_tc) begin
                  state_nxt = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            if (load_start) begin
               state_nxt = S_LOAD;
               cnt_clr   = 1'b1;
            end else begin
               clr_row = 1'b1;
               cnt_en  = 1'b1;
               if (row_tc) begin
                  state_nxt = S_READY;
               end
            end
         end
         S_READY: begin
            if (load_start) begin
               state_nxt = S_LOAD;
               cnt_clr   = 1'b1;
            end else if (clear_marks) begin
               state_nxt = S_CLEAR;
               cnt_clr   = 1'b1;
            end else if (mark) begin
               set_mark = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAZE_DIM; i++) begin
            wall[i] <= '0;
         end
      end else if (wr_row) begin
         wall[row] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAZE_DIM; i++) begin
            visited[i] <= '0;
         end
      end else begin
         if (clr_row) begin
            visited[row] <= '0;
         end
         if (set_mark) begin
            visited[Y][X] <= 1'b1;
         end
      end
   end

   assign load_ready = (state == S_LOAD);
   assign loaded     = (state == S_READY);
   assign busy       = (state == S_LOAD) || (state == S_CLEAR);
   assign Dout       = loaded ? (wall[Y][X] | visited[Y][X]) : 1'b1;
   assign bad_maze   = loaded & (wall[0][0] | wall[15][15]);

endmodule

// File: doc/maze_map.md
MAZE_MAP -- requirements
Module: maze_map

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port load_start, input, 1 bit: request to begin a new maze load.
REQ-004 SHALL have port load_valid, input, 1 bit: load_data carries a valid row.
REQ-005 SHALL have port load_data, input, 16 bits: one maze row; bit i is cell X=i, and 1 means wall.
REQ-006 SHALL have port load_ready, output, 1 bit: the block accepts a row this cycle.
REQ-007 SHALL have ports X and Y, input, 4 bits each: queried cell coordinates from the rat datapath.
REQ-008 SHALL have port mark, input, 1 bit: set the visited bit of cell (X,Y).
REQ-009 SHALL have port clear_marks, input, 1 bit: request to clear all visited bits.
REQ-010 SHALL have port Dout, output, 1 bit: cell (X,Y) is blocked (wall or visited); it feeds the datapath invalid logic.
REQ-011 SHALL have port loaded, output, 1 bit: the maze is valid and queries are meaningful.
REQ-012 SHALL have port busy, output, 1 bit: the block is in LOAD or CLEAR.
REQ-013 SHALL have port bad_maze, output, 1 bit: loaded, and cell (0,0) or cell (15,15) is a wall.

Function
REQ-014 SHALL hold storage wall[16][16] and visited[16][16] in flops.
REQ-015 SHALL implement the FSM states IDLE, LOAD, CLEAR and READY.
REQ-016 IDLE: load_start SHALL go to LOAD with row counter = 0; all other inputs SHALL be ignored.
REQ-017 LOAD: load_ready SHALL be 1.
REQ-018 LOAD: each load_valid cycle SHALL write load_data into wall[row] and increment row.
REQ-019 LOAD: acceptance of row 15 SHALL go to CLEAR with row = 0.
REQ-020 LOAD: load_valid = 0 SHALL stall without limit; state and row are held.
REQ-021 CLEAR: each cycle SHALL zero visited[row] and increment row.
REQ-022 CLEAR: after row 15 the block SHALL go to READY; CLEAR is exactly 16 cycles.
REQ-023 READY: mark SHALL set visited[Y][X] at the clock edge; Dout SHALL reflect it from the next cycle.
REQ-024 READY: clear_marks SHALL go to CLEAR with row = 0; walls are retained.
REQ-025 READY: load_start SHALL go to LOAD with row = 0; loaded drops to 0 in the next cycle.
REQ-026 load_start in LOAD or CLEAR SHALL restart LOAD at row 0; rows already written are overwritten later.
REQ-027 When load_start and clear_marks coincide, load_start SHALL win.
REQ-028 When clear_marks and mark coincide, clear_marks SHALL win and the mark is dropped.
REQ-029 mark and clear_marks SHALL be ignored outside READY.
REQ-030 Dout SHALL be combinational: wall[Y][X] | visited[Y][X] when in READY, else 1 (everything blocked).
REQ-031 loaded SHALL be 1 only in READY.
REQ-032 busy SHALL be 1 in LOAD and in CLEAR.
REQ-033 bad_maze SHALL equal loaded & (wall[0][0] | wall[15][15]).
REQ-034 The row counter SHALL be 4 bits; its wrap from 15 to 0 coincides with the state exit.
REQ-035 The row counter SHALL never wrap within a state.

Reset
REQ-036 Asserting rst (low) SHALL immediately force IDLE and row = 0.
REQ-037 Asserting rst SHALL immediately clear all wall and visited bits.
REQ-038 While rst is asserted, outputs SHALL be load_ready = 0, loaded = 0, busy = 0, bad_maze = 0 and Dout = 1.
REQ-039 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation; no partial state survives.

Structure
REQ-040 Package maze_pkg SHALL hold the state enum, MAZE_DIM = 16, IDX_W = 4 and a row_t typedef (logic [15:0]).
REQ-041 Sub-module maze_row_counter SHALL provide a 4-bit counter with sync clear, enable and terminal-count output.
REQ-042 maze_row_counter SHALL be shared by the LOAD and CLEAR states.

Verification
REQ-043 Reset, then load 16 rows of 16'h0000 with load_valid held high -> busy for 32 cycles, loaded = 1 at cycle 33, Dout = 0 for all (X,Y).
REQ-044 Load a maze with row 3 = 16'h0010, query X=4 Y=3 -> Dout = 1; query X=5 Y=3 -> Dout = 0.
REQ-045 READY, mark at (2,2) -> Dout = 1 at (2,2) the next cycle; clear_marks -> busy for 16 cycles, then Dout = 0 at (2,2).
REQ-046 Toggle load_valid every other cycle during LOAD -> exactly 16 rows are stored in order, and each row lands at the correct Y.
REQ-047 Assert rst after row 7 of a load -> IDLE, Dout = 1, loaded = 0; a fresh load then gives the correct map.
REQ-048 Load with row 0 = 16'h0001 -> bad_maze = 1; assert mark and clear_marks together -> clear wins and the visited bit is not set.
